// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, interval and lamp encodings for the intersection controller
package traffic_pkg;

    localparam int ST_W = 3;

    localparam logic [2:0] S_MAIN_GREEN     = 3'd0;
    localparam logic [2:0] S_MAIN_GREEN_EXT = 3'd1;
    localparam logic [2:0] S_MAIN_YELLOW    = 3'd2;
    localparam logic [2:0] S_PED_WALK       = 3'd3;
    localparam logic [2:0] S_SIDE_GREEN     = 3'd4;
    localparam logic [2:0] S_SIDE_GREEN_EXT = 3'd5;
    localparam logic [2:0] S_SIDE_YELLOW    = 3'd6;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] main_l;
        logic [2:0] side_l;
        logic       walk_l;
    } lamps_t;

    // Unknown encodings fall back to the reset lamp pattern.
    function automatic lamps_t lamps_of(input logic [2:0] st);
        lamps_t l;
        case (st)
            S_MAIN_GREEN, S_MAIN_GREEN_EXT: l = '{LAMP_GRN, LAMP_RED, 1'b0};
            S_MAIN_YELLOW:                  l = '{LAMP_YEL, LAMP_RED, 1'b0};
            S_PED_WALK:                     l = '{LAMP_RED, LAMP_RED, 1'b1};
            S_SIDE_GREEN, S_SIDE_GREEN_EXT: l = '{LAMP_RED, LAMP_GRN, 1'b0};
            S_SIDE_YELLOW:                  l = '{LAMP_RED, LAMP_YEL, 1'b0};
            default:                        l = '{LAMP_GRN, LAMP_RED, 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_fsm_walk_latch.sv
// rtl/traffic_fsm_walk_latch.sv - pedestrian request register, set beats clear
module walk_latch (
    input  logic clock,
    input  logic flush,
    input  logic set,
    input  logic clr,
    output logic pending
);

    logic pending_q;
    logic pending_d;

    always_comb begin
        pending_d = pending_q;
        if (set) begin
            pending_d = 1'b1;
        end else if (clr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/traffic_fsm.sv
// rtl/traffic_fsm.sv - intersection phase sequencer driving timer start, interval select and lamps
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int ST_W = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       expired,
    input  logic       side_sensor,
    input  logic       walk_button,
    input  logic       reprogram,
    output logic       start_timer,
    output logic [1:0] interval_sel,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk
);

    logic [ST_W-1:0] state_q, state_d, nxt;
    logic            start_timer_q, start_timer_d;
    logic [1:0]      interval_sel_q, interval_sel_d, nxt_sel;
    logic [2:0]      main_light_q, main_light_d;
    logic [2:0]      side_light_q, side_light_d;
    logic            walk_q, walk_d;
    logic            walk_pending, walk_clr, legal, advance;
    lamps_t          nxt_lamps;

    walk_latch u_walk_latch (
        .clock   (clock),
        .flush   (reset | reprogram),
        .set     (walk_button),
        .clr     (walk_clr),
        .pending (walk_pending)
    );

    always_comb begin
        nxt     = state_q;
        nxt_sel = interval_sel_q;
        legal   = 1'b1;
        case (state_q)
            S_MAIN_GREEN: begin
                nxt     = S_MAIN_GREEN_EXT;
                nxt_sel = side_sensor ? INT_EXT : INT_BASE;
            end
            S_MAIN_GREEN_EXT: begin
                nxt     = S_MAIN_YELLOW;
                nxt_sel = INT_YEL;
            end
            S_MAIN_YELLOW: begin
                nxt     = walk_pending ? S_PED_WALK : S_SIDE_GREEN;
                nxt_sel = walk_pending ? INT_EXT : INT_BASE;
            end
            S_PED_WALK: begin
                nxt     = S_SIDE_GREEN;
                nxt_sel = INT_BASE;
            end
            S_SIDE_GREEN: begin
                nxt     = side_sensor ? S_SIDE_GREEN_EXT : S_SIDE_YELLOW;
                nxt_sel = side_sensor ? INT_EXT : INT_YEL;
            end
            S_SIDE_GREEN_EXT: begin
                nxt     = S_SIDE_YELLOW;
                nxt_sel = INT_YEL;
            end
            S_SIDE_YELLOW: begin
                nxt     = S_MAIN_GREEN;
                nxt_sel = INT_BASE;
            end
            default: begin
                legal   = 1'b0;
                nxt     = S_MAIN_GREEN;
                nxt_sel = INT_BASE;
            end
        endcase
    end

    // The timer is still loading during the start cycle, so expired is only trusted afterwards.
    always_comb begin
        advance        = expired & ~start_timer_q;
        nxt_lamps      = lamps_of(nxt);
        state_d        = state_q;
        start_timer_d  = 1'b0;
        interval_sel_d = interval_sel_q;
        main_light_d   = main_light_q;
        side_light_d   = side_light_q;
        walk_d         = walk_q;
        walk_clr       = 1'b0;
        if (advance || !legal) begin
            state_d        = nxt;
            start_timer_d  = 1'b1;
            interval_sel_d = nxt_sel;
            main_light_d   = nxt_lamps.main_l;
            side_light_d   = nxt_lamps.side_l;
            walk_d         = nxt_lamps.walk_l;
            walk_clr       = legal && (nxt == S_PED_WALK);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || reprogram) begin
            state_q        <= S_MAIN_GREEN;
            start_timer_q  <= 1'b1;
            interval_sel_q <= INT_BASE;
            main_light_q   <= LAMP_GRN;
            side_light_q   <= LAMP_RED;
            walk_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_timer_q  <= start_timer_d;
            interval_sel_q <= interval_sel_d;
            main_light_q   <= main_light_d;
            side_light_q   <= side_light_d;
            walk_q         <= walk_d;
        end
    end

    assign start_timer  = start_timer_q;
    assign interval_sel = interval_sel_q;
    assign main_light   = main_light_q;
    assign side_light   = side_light_q;
    assign walk         = walk_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// tb/tb_traffic_fsm.sv - directed self-checking bench for traffic_fsm with a countdown timer model
module tb_traffic_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       side_sensor = 1'b0;
    logic       walk_button = 1'b0;
    logic       reprogram = 1'b0;
    logic       exp_force = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;

    int tests = 0;
    int failed = 0;
    int tmr_cnt = 0;

    // {interval_sel, main, side, walk} expected at the start cycle of each phase
    localparam logic [8:0] P_MG    = {2'b00, 3'b001, 3'b100, 1'b0};
    localparam logic [8:0] P_MGE_X = {2'b01, 3'b001, 3'b100, 1'b0};
    localparam logic [8:0] P_MY    = {2'b10, 3'b010, 3'b100, 1'b0};
    localparam logic [8:0] P_PW    = {2'b01, 3'b100, 3'b100, 1'b1};
    localparam logic [8:0] P_SG    = {2'b00, 3'b100, 3'b001, 1'b0};
    localparam logic [8:0] P_SGE   = {2'b01, 3'b100, 3'b001, 1'b0};
    localparam logic [8:0] P_SY    = {2'b10, 3'b100, 3'b010, 1'b0};

    traffic_fsm #(.ST_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .expired      (expired),
        .side_sensor  (side_sensor),
        .walk_button  (walk_button),
        .reprogram    (reprogram),
        .start_timer  (start_timer),
        .interval_sel (interval_sel),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk         (walk)
    );

    always #5 clock = ~clock;

    // Timer: expired rises N cycles after the start_timer cycle and stays high at zero
    always @(posedge clock) begin
        if (reset) begin
            tmr_cnt <= 0;
        end else if (start_timer) begin
            case (interval_sel)
                2'b00:   tmr_cnt <= 5;
                2'b01:   tmr_cnt <= 2;
                2'b10:   tmr_cnt <= 1;
                default: tmr_cnt <= 0;
            endcase
        end else if (tmr_cnt != 0) begin
            tmr_cnt <= tmr_cnt - 1;
        end
    end

    assign expired = (tmr_cnt == 0) || exp_force;

    wire [8:0] obs = {interval_sel, main_light, side_light, walk};

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Steps from one start cycle to the next; cycles = -1 if no start pulse appears
    task automatic run_phase(input int pulse_at, output int cycles);
        cycles = 0;
        do begin
            walk_button = (cycles == pulse_at);
            @(negedge clock);
            cycles++;
        end while (!start_timer && cycles < 40);
        walk_button = 1'b0;
        if (!start_timer) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if ({start_timer, obs} !== {1'b1, P_MG}) begin
            failed++;
            $display("FAIL reset_outputs got %b required %b", {start_timer, obs}, {1'b1, P_MG});
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({start_timer, obs} !== {1'b0, P_MG}) begin
            failed++;
            $display("FAIL reset_release_hold got %b required %b", {start_timer, obs}, {1'b0, P_MG});
        end
    endtask

    task automatic test_normal_cycle();
        logic [8:0] ph [6] = '{P_MG, P_MG, P_MY, P_SG, P_SY, P_MG};
        int len [6] = '{7, 7, 3, 7, 3, 0};
        int c;
        side_sensor = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (obs !== ph[i]) begin
                failed++;
                $display("FAIL normal_phase%0d got %b required %b", i, obs, ph[i]);
            end
            if (i < 5) begin
                run_phase(-1, c);
                tests++;
                if (c != len[i]) begin
                    failed++;
                    $display("FAIL normal_len%0d got %0d required %0d", i, c, len[i]);
                end
            end
        end
    endtask

    task automatic test_side_sensor();
        logic [8:0] ph [7] = '{P_MG, P_MGE_X, P_MY, P_SG, P_SGE, P_SY, P_MG};
        int len [7] = '{7, 4, 3, 7, 4, 3, 0};
        int c;
        side_sensor = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (obs !== ph[i]) begin
                failed++;
                $display("FAIL side_phase%0d got %b required %b", i, obs, ph[i]);
            end
            if (i < 6) begin
                run_phase(-1, c);
                tests++;
                if (c != len[i]) begin
                    failed++;
                    $display("FAIL side_len%0d got %0d required %0d", i, c, len[i]);
                end
            end
        end
        side_sensor = 1'b0;
    endtask

    task automatic test_walk_request();
        logic [8:0] ph [10] = '{P_MG, P_MG, P_MY, P_PW, P_SG, P_SY, P_MG, P_MG, P_MY, P_SG};
        int len [10] = '{7, 7, 3, 4, 7, 3, 7, 7, 3, 0};
        int pls [10] = '{0, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        int c;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (obs !== ph[i]) begin
                failed++;
                $display("FAIL walk_phase%0d got %b required %b", i, obs, ph[i]);
            end
            if (i < 9) begin
                run_phase(pls[i], c);
                tests++;
                if (c != len[i]) begin
                    failed++;
                    $display("FAIL walk_len%0d got %0d required %0d", i, c, len[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_walk();
        logic [8:0] ph [16] = '{P_MG, P_MG, P_MY, P_PW, P_SG, P_SY, P_MG, P_MG, P_MY, P_PW,
                                P_SG, P_SY, P_MG, P_MG, P_MY, P_SG};
        int len [16] = '{7, 7, 3, 4, 7, 3, 7, 7, 3, 4, 7, 3, 7, 7, 3, 0};
        int pls [16] = '{0, -1, 2, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        int c;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (obs !== ph[i]) begin
                failed++;
                $display("FAIL b2b_phase%0d got %b required %b", i, obs, ph[i]);
            end
            if (i < 15) begin
                run_phase(pls[i], c);
                tests++;
                if (c != len[i]) begin
                    failed++;
                    $display("FAIL b2b_len%0d got %0d required %0d", i, c, len[i]);
                end
            end
        end
    endtask

    task automatic test_expired_held();
        logic [8:0] ph [6] = '{P_MG, P_MG, P_MY, P_SG, P_SY, P_MG};
        int c;
        exp_force = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (obs !== ph[i]) begin
                failed++;
                $display("FAIL held_phase%0d got %b required %b", i, obs, ph[i]);
            end
            if (i < 5) begin
                run_phase(-1, c);
                tests++;
                if (c != 2) begin
                    failed++;
                    $display("FAIL held_len%0d got %0d required 2", i, c);
                end
            end
        end
        exp_force = 1'b0;
    endtask

    task automatic test_reprogram();
        int c;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            run_phase(-1, c);
            run_phase(-1, c);
            run_phase(-1, c);
            tests++;
            if (obs !== P_SG) begin
                failed++;
                $display("FAIL reprog%0d_reach_sg got %b required %b", k, obs, P_SG);
            end
            walk_button = 1'b1;
            @(negedge clock);
            walk_button = 1'b0;
            @(negedge clock);
            reprogram = 1'b1;
            reset = (k == 1);
            @(negedge clock);
            reprogram = 1'b0;
            reset = 1'b0;
            tests++;
            if ({start_timer, obs} !== {1'b1, P_MG}) begin
                failed++;
                $display("FAIL reprog%0d_restart got %b required %b", k, {start_timer, obs}, {1'b1, P_MG});
            end
            run_phase(-1, c);
            run_phase(-1, c);
            run_phase(-1, c);
            tests++;
            if (obs !== P_SG) begin
                failed++;
                $display("FAIL reprog%0d_pending_cleared got %b required %b", k, obs, P_SG);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_side_sensor();
        test_walk_request();
        test_back_to_back_walk();
        test_expired_held();
        test_reprogram();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/traffic_fsm.md
Name: traffic_fsm

Overview:
- Sequencing controller for the traffic-light intersection; the direct consumer of the countdown timer's expired flag and the producer of its start_timer pulse.
- Also drives interval_sel to the time-parameter lookup, whose output feeds the timer's value input.
- Walks main/side/pedestrian phases and latches the walk button.
- Owns all lamp outputs.

Parameters:
- ST_W, 3, state register width (7 states used).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- expired  in  1  timer count reached zero (level)
- side_sensor  in  1  car waiting on side street (level, synchronised upstream)
- walk_button  in  1  pedestrian request (single-cycle pulse, debounced upstream)
- reprogram  in  1  synchronous restart after interval reprogramming
- start_timer  out  1  one-cycle pulse: timer loads value
- interval_sel  out  2  00 BASE, 01 EXT, 10 YEL, 11 unused
- main_light  out  3  {red,yellow,green}
- side_light  out  3  {red,yellow,green}
- walk  out  1  pedestrian walk lamp

Behaviour:
- All outputs registered. On reset or reprogram (both sampled at posedge, reset dominant):
  - state=MAIN_GREEN, walk_pending=0, main_light=001, side_light=100, walk=0.
  - interval_sel=00, start_timer=1 in the first cycle after.
- Every state entry:
  - start_timer=1 for exactly that first cycle; interval_sel is updated in the same edge and held for the whole state.
  - The timer samples value in the start_timer cycle.
- expired is ignored while start_timer=1. A transition occurs on the edge where expired=1 and start_timer=0. Latency from qualifying expired to new lamps + start_timer is 1 cycle.
- States, with interval, lamps (main/side/walk) and exit on expiry:
  - MAIN_GREEN: BASE; 001/100/0; -> MAIN_GREEN_EXT.
  - MAIN_GREEN_EXT: EXT if side_sensor=1 at the transition edge into it, else BASE; 001/100/0; -> MAIN_YELLOW.
  - MAIN_YELLOW: YEL; 010/100/0; -> PED_WALK if walk_pending, else SIDE_GREEN.
  - PED_WALK: EXT; 100/100/1; -> SIDE_GREEN. Clears walk_pending on entry.
  - SIDE_GREEN: BASE; 100/001/0; -> SIDE_GREEN_EXT if side_sensor=1 at exit edge, else SIDE_YELLOW.
  - SIDE_GREEN_EXT: EXT; 100/001/0; -> SIDE_YELLOW.
  - SIDE_YELLOW: YEL; 100/010/0; -> MAIN_GREEN.
- Illegal state encoding -> MAIN_GREEN with start_timer pulse; lamps forced to reset values.
- walk_pending:
  - set by walk_button in any state.
  - Set and PED_WALK-entry clear on the same edge: set wins, so the request is served on the next cycle round.
  - Presses during PED_WALK stay pending for the next round.
- Never green or yellow on both streets simultaneously; walk=1 only with both streets red.
- reprogram mid-phase aborts the phase immediately; no yellow is inserted.

Decomposition:
- Shared package (traffic_pkg):
  - state encodings.
  - interval codes INT_BASE/INT_EXT/INT_YEL.
  - lamp constants RED=100, YEL=010, GRN=001.
  - Also imported by the time-parameter block.
- One natural sub-module: walk_latch (set/clear register with set priority).
- FSM next-state and output decode stay in traffic_fsm.

Test Plan (bench timer model asserts expired N cycles after start_timer: BASE=6, EXT=3, YEL=2):
- Reset released, side_sensor=0, no walk -> start_timer at cycle 1; interval_sel sequence 00,00,10,00,10 over states MG, MGE, MY, SG, SY; returns to MG; lamps match the state list.
- side_sensor=1 throughout -> MGE selects 01; SG exits to SGE (01) then SY; full cycle takes 6+3+2+6+3+2 timer periods.
- walk_button pulse during MG -> after MY, PED_WALK with walk=1, main=side=100, interval 01; walk_pending=0 afterwards; the next round skips PED_WALK.
- walk_button pulse on the exact MY->PED_WALK edge -> PED_WALK serviced now and again on the next round.
- expired held high through the start_timer cycle -> no double transition; the state advances only after start_timer drops.
- reprogram asserted mid SIDE_GREEN -> next cycle: MAIN_GREEN, main=001, side=100, start_timer=1, walk_pending cleared. Reset together with reprogram behaves identically.
